// File: rtl/reaction_delay_timer.sv
`default_nettype none
// ============================================================================
// Module  : reaction_delay_timer
// Brief   : Random pre-stimulus wait from an LFSR seed, then reaction-time
//           measurement in ms ticks with false-start and timeout flags.
// Revision: 1.0 - initial release
// ============================================================================
module reaction_delay_timer #(
  parameter int TICK_DIV     = 50000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int DELAY_SHIFT  = 4,
  parameter int TIMEOUT_MS   = 1000,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic [7:0]       seed,
  input  logic             seed_valid,
  input  logic             button,
  output logic             led,
  output logic             busy,
  output logic [CNT_W-1:0] rt_ms,
  output logic             rt_valid,
  output logic             false_start,
  output logic             timeout
);

  localparam int               c_PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICK_DIV - 1);
  localparam logic [c_PRE_W-1:0] c_PRE_ONE  = c_PRE_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_MIN_DELAY = CNT_W'(MIN_DELAY_MS);
  localparam logic [CNT_W-1:0] c_TO_MS     = CNT_W'(TIMEOUT_MS);
  localparam logic [CNT_W-1:0] c_TO_LAST   = CNT_W'(TIMEOUT_MS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEED  = 2'd1,
    S_DELAY = 2'd2,
    S_ARMED = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic               r_btn_meta;
  logic               r_btn_sync;
  logic               r_btn_prev;
  logic               w_press;

  logic [c_PRE_W-1:0] r_presc;
  logic [CNT_W-1:0]   r_ms_cnt;
  logic [CNT_W-1:0]   r_delay_ms;
  logic [CNT_W-1:0]   w_seed_delay;
  logic               w_tick;
  logic               w_delay_done;
  logic               w_timeout_hit;

  logic               w_cnt_clr;
  logic               w_load_delay;
  logic               w_clr_results;
  logic               w_set_fs;
  logic               w_set_rt;
  logic               w_set_to;

  logic [CNT_W-1:0]   r_rt_ms;
  logic               r_rt_valid;
  logic               r_false_start;
  logic               r_timeout;

  // Button is asynchronous: two-flop synchroniser plus edge detector.
  always_ff @(posedge clk) begin
    if (res) begin
      r_btn_meta <= 1'b0;
      r_btn_sync <= 1'b0;
      r_btn_prev <= 1'b0;
    end else begin
      r_btn_meta <= button;
      r_btn_sync <= r_btn_meta;
      r_btn_prev <= r_btn_sync;
    end
  end

  assign w_press       = r_btn_sync & ~r_btn_prev;
  assign w_tick        = (r_presc == c_PRE_LAST);
  assign w_seed_delay  = c_MIN_DELAY + (CNT_W'(seed) << DELAY_SHIFT);
  assign w_delay_done  = w_tick && (r_ms_cnt == (r_delay_ms - c_CNT_ONE));
  assign w_timeout_hit = w_tick && (r_ms_cnt == c_TO_LAST);

  always_ff @(posedge clk) begin
    if (res) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_clr     = 1'b0;
    w_load_delay  = 1'b0;
    w_clr_results = 1'b0;
    w_set_fs      = 1'b0;
    w_set_rt      = 1'b0;
    w_set_to      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt   = S_SEED;
          w_clr_results = 1'b1;
        end
      end
      S_SEED: begin
        if (seed_valid) begin
          w_state_nxt  = S_DELAY;
          w_load_delay = 1'b1;
          w_cnt_clr    = 1'b1;
        end
      end
      S_DELAY: begin
        // An early press beats a coincident final tick.
        if (w_press) begin
          w_state_nxt = S_IDLE;
          w_set_fs    = 1'b1;
        end else if (w_delay_done) begin
          w_state_nxt = S_ARMED;
          w_cnt_clr   = 1'b1;
        end
      end
      S_ARMED: begin
        if (w_press) begin
          w_state_nxt = S_IDLE;
          w_set_rt    = 1'b1;
        end else if (w_timeout_hit) begin
          w_state_nxt = S_IDLE;
          w_set_to    = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Timebase only runs in DELAY/ARMED and restarts on entry to each.
  always_ff @(posedge clk) begin
    if (res || w_cnt_clr || !((r_state == S_DELAY) || (r_state == S_ARMED))) begin
      r_presc  <= '0;
      r_ms_cnt <= '0;
    end else if (w_tick) begin
      r_presc  <= '0;
      r_ms_cnt <= r_ms_cnt + c_CNT_ONE;
    end else begin
      r_presc  <= r_presc + c_PRE_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_delay_ms <= '0;
    end else if (w_load_delay) begin
      r_delay_ms <= w_seed_delay;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_rt_ms       <= '0;
      r_rt_valid    <= 1'b0;
      r_false_start <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      if (w_clr_results) begin
        r_rt_valid    <= 1'b0;
        r_false_start <= 1'b0;
        r_timeout     <= 1'b0;
      end
      if (w_set_fs) begin
        r_false_start <= 1'b1;
      end
      if (w_set_rt) begin
        r_rt_ms    <= r_ms_cnt;
        r_rt_valid <= 1'b1;
      end
      if (w_set_to) begin
        r_rt_ms   <= c_TO_MS;
        r_timeout <= 1'b1;
      end
    end
  end

  assign led         = (r_state == S_ARMED);
  assign busy        = (r_state != S_IDLE);
  assign rt_ms       = r_rt_ms;
  assign rt_valid    = r_rt_valid;
  assign false_start = r_false_start;
  assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_reaction_delay_timer.sv
`default_nettype none
// ============================================================================
// Module  : tb_reaction_delay_timer
// Brief   : Table-driven trials with a result scoreboard plus reset/held-button
//           sequences for reaction_delay_timer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_reaction_delay_timer;

  localparam int TD    = 4;
  localparam int MIN   = 10;
  localparam int SHIFT = 2;
  localparam int TO    = 50;
  localparam int W     = 16;
  localparam int LIMIT = 6000;

  localparam int MODE_NONE  = 0;
  localparam int MODE_DELAY = 1;
  localparam int MODE_ARMED = 2;

  typedef struct {
    logic [7:0] seed;
    int         wait_c;
    int         mode;
    int         prm;
    bit         e_rv;
    bit         e_fs;
    bit         e_to;
    int         e_rt;
  } vec_t;

  typedef struct {
    bit rv;
    bit fs;
    bit to;
    int rt;
    int led_c;
    int end_c;
  } exp_t;

  logic         clk = 1'b0;
  logic         res;
  logic         start;
  logic [7:0]   seed;
  logic         seed_valid;
  logic         button;
  logic         led;
  logic         busy;
  logic [W-1:0] rt_ms;
  logic         rt_valid;
  logic         false_start;
  logic         timeout;

  int   n_checks = 0;
  int   n_errors = 0;
  int   m_rt     = 0;
  exp_t sb[$];
  vec_t vecs[7];

  reaction_delay_timer #(
    .TICK_DIV    (TD),
    .MIN_DELAY_MS(MIN),
    .DELAY_SHIFT (SHIFT),
    .TIMEOUT_MS  (TO),
    .CNT_W       (W)
  ) u_dut (
    .clk        (clk),
    .res        (res),
    .start      (start),
    .seed       (seed),
    .seed_valid (seed_valid),
    .button     (button),
    .led        (led),
    .busy       (busy),
    .rt_ms      (rt_ms),
    .rt_valid   (rt_valid),
    .false_start(false_start),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // c counts edges since entry to DELAY; the press pulse acts 3 edges after
  // the raw button rises.
  task automatic run_trial(input logic [7:0] sd, input int w, input int mode, input int prm,
                           input bit rv, input bit fs, input bit to, input int rt_in);
    exp_t e;
    int   d_cyc;
    int   raise_c;
    int   c;
    int   led_c;
    bit   wait_ok;
    bit   done;
    d_cyc   = (MIN + (int'(sd) << SHIFT)) * TD;
    e.rv    = rv;
    e.fs    = fs;
    e.to    = to;
    e.rt    = (rt_in < 0) ? m_rt : rt_in;
    e.led_c = (mode == MODE_DELAY) ? -1 : d_cyc;
    e.end_c = (mode == MODE_DELAY) ? prm : (mode == MODE_ARMED) ? d_cyc + prm : d_cyc + TO * TD;
    raise_c = (mode == MODE_DELAY) ? prm - 3 : (mode == MODE_ARMED) ? d_cyc + prm - 3 : -100;
    sb.push_back(e);

    start      = 1'b1;
    seed       = 8'hA5 ^ sd;
    seed_valid = (w == 0);
    step();
    start = 1'b0;
    chk("accept_flags_clear", {rt_valid, false_start, timeout}, 0);
    chk("accept_rt_hold", rt_ms, m_rt);
    chk("accept_busy", busy, 1);
    if (w == 0) begin
      seed = sd;
    end else begin
      wait_ok = 1'b1;
      repeat (w) begin
        step();
        if (!busy || led) wait_ok = 1'b0;
      end
      chk("seed_wait_busy_noled", wait_ok, 1);
      seed       = sd;
      seed_valid = 1'b1;
    end
    step();
    seed = ~sd;

    c     = 0;
    led_c = -1;
    done  = 1'b0;
    while (!done && c < LIMIT) begin
      if (c == raise_c - 2) button = 1'b0;
      if (c == raise_c) button = 1'b1;
      step();
      c++;
      if (led && led_c < 0) led_c = c;
      if (!busy) done = 1'b1;
    end

    e = sb.pop_front();
    if (!done) begin
      chk("trial_end_bound", 0, 1);
    end else begin
      chk("led_on_cycle", led_c, e.led_c);
      chk("trial_end_cycle", c, e.end_c);
      chk("rt_valid", rt_valid, e.rv);
      chk("false_start", false_start, e.fs);
      chk("timeout", timeout, e.to);
      chk("rt_ms", rt_ms, e.rt);
      chk("led_off_at_end", led, 0);
    end
    m_rt   = e.rt;
    button = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    vecs[0] = '{8'd3,   0,  MODE_ARMED, 32,  1'b1, 1'b0, 1'b0, 7};
    vecs[1] = '{8'd0,   0,  MODE_DELAY, 20,  1'b0, 1'b1, 1'b0, -1};
    vecs[2] = '{8'd5,   0,  MODE_ARMED, 1,   1'b1, 1'b0, 1'b0, 0};
    vecs[3] = '{8'd1,   0,  MODE_NONE,  0,   1'b0, 1'b0, 1'b1, 50};
    vecs[4] = '{8'd255, 30, MODE_ARMED, 5,   1'b1, 1'b0, 1'b0, 1};
    vecs[5] = '{8'd0,   0,  MODE_DELAY, 40,  1'b0, 1'b1, 1'b0, -1};
    vecs[6] = '{8'd2,   0,  MODE_ARMED, 200, 1'b1, 1'b0, 1'b0, 49};

    res        = 1'b1;
    start      = 1'b0;
    seed       = 8'd0;
    seed_valid = 1'b0;
    button     = 1'b0;
    step();
    step();
    chk("reset_busy", busy, 0);
    chk("reset_led", led, 0);
    chk("reset_flags", {rt_valid, false_start, timeout}, 0);
    chk("reset_rt_ms", rt_ms, 0);
    res = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      run_trial(vecs[i].seed, vecs[i].wait_c, vecs[i].mode, vecs[i].prm,
                vecs[i].e_rv, vecs[i].e_fs, vecs[i].e_to, vecs[i].e_rt);
    end

    // Abort a trial in ARMED at ms_cnt=5 with the button going high.
    start      = 1'b1;
    seed       = 8'd0;
    seed_valid = 1'b1;
    step();
    start = 1'b0;
    step();
    repeat (40) step();
    chk("armed_before_reset", led, 1);
    repeat (20) step();
    res    = 1'b1;
    button = 1'b1;
    step();
    res = 1'b0;
    chk("midreset_busy", busy, 0);
    chk("midreset_led", led, 0);
    chk("midreset_flags", {rt_valid, false_start, timeout}, 0);
    chk("midreset_rt_ms", rt_ms, 0);
    m_rt = 0;
    repeat (6) step();
    chk("held_idle_busy", busy, 0);
    chk("held_idle_flags", {rt_valid, false_start, timeout}, 0);

    // Button stays held through DELAY: no false start until released and re-pressed.
    run_trial(8'd0, 0, MODE_ARMED, 10, 1'b1, 1'b0, 1'b0, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
